// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and the conditioned level, strobe and hold outputs
interface button_conditioner_if;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;
    logic [2:0] btn_release;
    logic [2:0] btn_long;
    modport master(output btn_raw, input btn_level, btn_pulse, btn_release, btn_long);
    modport slave(input btn_raw, output btn_level, btn_pulse, btn_release, btn_long);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-button sync, debounce, and press/auto-repeat/long-hold/release strobes
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE = 5_000_000,
    parameter logic [2:0] REPEAT_MASK = 3'b010
) (
    input logic clk,
    input logic reset,
    button_conditioner_if.slave bus
);
    localparam int MAX_DR = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAXC = MAX_DR > REPEAT_RATE ? MAX_DR : REPEAT_RATE;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_e;

    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0] level_q, level_d, pulse_q, pulse_d, release_q, release_d, long_q, long_d;
    logic [CW-1:0] db_q [3];
    logic [CW-1:0] db_d [3];
    logic [CW-1:0] hold_q [3];
    logic [CW-1:0] hold_d [3];
    state_e state_q [3];
    state_e state_d [3];

    always_comb begin
        sync1_d = bus.btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        pulse_d = '0;
        release_d = '0;
        long_d = long_q;
        for (int i = 0; i < 3; i++) begin
            db_d[i] = '0;
            hold_d[i] = hold_q[i];
            state_d[i] = state_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (db_q[i] == DB_LAST) level_d[i] = ~level_q[i];
                else db_d[i] = db_q[i] + 1'b1;
            end
            // FSM keys off level_d so strobes line up with the cycle the level first changes
            case (state_q[i])
                IDLE: if (level_d[i]) begin
                    pulse_d[i] = 1'b1;
                    hold_d[i] = '0;
                    state_d[i] = HELD;
                end
                HELD, REPEAT: if (!level_d[i]) begin
                    release_d[i] = 1'b1;
                    long_d[i] = 1'b0;
                    hold_d[i] = '0;
                    state_d[i] = IDLE;
                end else if (hold_q[i] == (state_q[i] == HELD ? RD_LAST : RR_LAST)) begin
                    pulse_d[i] = REPEAT_MASK[i];
                    long_d[i] = 1'b1;
                    hold_d[i] = '0;
                    state_d[i] = REPEAT;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            release_q <= '0;
            long_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_q[i] <= '0;
                hold_q[i] <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            release_q <= release_d;
            long_q <= long_d;
            for (int i = 0; i < 3; i++) begin
                db_q[i] <= db_d[i];
                hold_q[i] <= hold_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_pulse = pulse_q;
    assign bus.btn_release = release_q;
    assign bus.btn_long = long_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed button stimulus against an event-time reference model
module tb_button_conditioner;
    localparam int D = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam logic [2:0] MASK = 3'b010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    button_conditioner_if bus();

    button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;
    logic [11:0] exp_q[$];
    logic [2:0] hist [0:D+1];
    logic [2:0] m_level;
    int t_press [3];

    function automatic void model_reset();
        for (int k = 0; k <= D + 1; k++) hist[k] = '0;
        m_level = '0;
    endfunction

    // Level follows raw once the synchronised value has disagreed for D straight cycles;
    // strobes are derived from the age of the press in cycles.
    function automatic void step(input logic [2:0] raw);
        logic [2:0] lv, pu, rl, lg;
        int age;
        n++;
        for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw;
        pu = '0; rl = '0; lg = '0; lv = m_level;
        for (int c = 0; c < 3; c++) begin
            logic diff;
            diff = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (hist[k][c] == m_level[c]) diff = 1'b0;
            if (diff) lv[c] = ~m_level[c];
            if (lv[c] && !m_level[c]) begin
                t_press[c] = n;
                pu[c] = 1'b1;
            end else if (!lv[c] && m_level[c]) begin
                rl[c] = 1'b1;
            end else if (lv[c]) begin
                age = n - t_press[c];
                lg[c] = age >= RD;
                pu[c] = MASK[c] && age >= RD && ((age - RD) % RR) == 0;
            end
        end
        m_level = lv;
        exp_q.push_back({lv, pu, rl, lg});
    endfunction

    task automatic tick(input logic [2:0] raw, input logic rst_pulse);
        @(negedge clk);
        #1;
        bus.btn_raw = raw;
        reset = 1'b0;
        if (rst_pulse) begin
            reset = 1'b1;
            #2 reset = 1'b0;
            model_reset();
        end
        @(posedge clk);
        #1 step(raw);
    endtask

    task automatic hold(input logic [2:0] raw, input int cycles);
        for (int i = 0; i < cycles; i++) tick(raw, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e, got;
            e = exp_q.pop_front();
            got = {bus.btn_level, bus.btn_pulse, bus.btn_release, bus.btn_long};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL outputs @%0t lvl/pulse/rel/long got %b_%b_%b_%b required %b_%b_%b_%b",
                         $time, got[11:9], got[8:6], got[5:3], got[2:0], e[11:9], e[8:6], e[5:3], e[2:0]);
            end
        end
    end

    initial begin
        bus.btn_raw = '0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1 exp_q.push_back('0);
        end
        hold(3'b000, 4);
        hold(3'b001, 30);
        hold(3'b000, 10);
        hold(3'b010, 50);
        hold(3'b000, 10);
        hold(3'b100, 3);
        hold(3'b000, 12);
        hold(3'b111, 10);
        hold(3'b000, 10);
        hold(3'b010, 35);
        tick(3'b010, 1'b1);
        hold(3'b010, 12);
        hold(3'b000, 10);
        for (int s = 0; s < 60; s++) begin
            logic [2:0] r;
            int len;
            r = 3'($urandom_range(0, 7));
            len = $urandom_range(0, 1) ? $urandom_range(1, 5) : $urandom_range(6, 45);
            tick(r, $urandom_range(0, 19) == 0);
            hold(r, len - 1);
        end
        hold(3'b000, 10);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a debounced level changes (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25_000_000, hold cycles from press pulse to first repeat pulse (500 ms).
REQ-003 SHALL have parameter REPEAT_RATE, default 5_000_000, cycles between subsequent repeat pulses (100 ms).
REQ-004 SHALL have parameter REPEAT_MASK, default 3'b010, per-button auto-repeat enable; bit0 start, bit1 inc, bit2 submit.
REQ-005 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-006 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port btn_raw, input, 3, raw asynchronous button levels, active-high, {submit, inc, start}.
REQ-008 SHALL have port btn_level, output, 3, debounced button levels.
REQ-009 SHALL have port btn_pulse, output, 3, one-cycle press or auto-repeat strobes.
REQ-010 SHALL have port btn_release, output, 3, one-cycle release strobes.
REQ-011 SHALL have port btn_long, output, 3, high while a button is held at least REPEAT_DELAY cycles past its press pulse.

Function
REQ-012 SHALL process each of the 3 buttons by an identical, independent channel; simultaneous events on different buttons SHALL produce their outputs in the same cycle.
REQ-013 SHALL synchronise each btn_raw bit through two flops (sync1, sync2) before any other use.
REQ-014 SHALL clear the debounce counter whenever sync2 equals btn_level; otherwise increment it.
REQ-015 SHALL toggle btn_level and clear the counter on the cycle the counter reaches DEBOUNCE_CYCLES-1 while sync2 still differs.
REQ-016 SHALL, with btn_raw stable, change btn_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value.
REQ-017 SHALL ignore any raw excursion shorter than DEBOUNCE_CYCLES synchronised cycles; btn_level, btn_pulse and btn_release SHALL not change.
REQ-018 SHALL implement the per-channel FSM IDLE -> HELD -> REPEAT, with all outputs registered.
REQ-019 SHALL, in IDLE, on btn_level rising, assert btn_pulse for the cycle in which btn_level is first 1, clear the hold counter, and enter HELD.
REQ-020 SHALL, in HELD, increment the hold counter each cycle; when REPEAT_DELAY cycles have elapsed since the press pulse, assert btn_long, enter REPEAT, clear the counter, and assert btn_pulse that cycle if REPEAT_MASK is set.
REQ-021 SHALL, in REPEAT, keep btn_long high and assert btn_pulse every REPEAT_RATE cycles if REPEAT_MASK is set; the counter SHALL wrap to 0 at each repeat and never overflow.
REQ-022 SHALL, on btn_level falling in HELD or REPEAT, assert btn_release for the cycle btn_level is first 0, deassert btn_long that same cycle, clear the counter, and return to IDLE with no btn_pulse in that cycle.
REQ-023 SHALL never assert btn_pulse and btn_release in the same cycle on one channel.
REQ-024 SHALL size counters as ceil(log2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1)) bits.

Reset
REQ-025 SHALL, while reset is high, force all sync flops, btn_level, btn_pulse, btn_release, btn_long, and counters to 0, with every FSM in IDLE.
REQ-026 SHALL, if a button is held through reset release, treat it as a new press: full debounce, then one btn_pulse, and no btn_release.
REQ-027 SHALL, on reset asserted mid-hold or mid-repeat, drop every output to 0 asynchronously and emit no btn_release.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-028 SHALL check: btn_raw[0] rises and holds -> btn_level[0]=1 and btn_pulse[0]=1 exactly 6 edges later, single cycle; btn_long[0] rises 20 cycles after the pulse with no further pulses (mask bit 0).
REQ-029 SHALL check: btn_raw[1] held for 40 cycles past its press pulse -> btn_pulse[1] at offsets 0, 20, 25, 30, 35, 40, and btn_long[1]=1 from offset 20.
REQ-030 SHALL check: 3-cycle high glitch on btn_raw[2] -> no change on any output.
REQ-031 SHALL check: release of btn_raw[1] during REPEAT -> btn_release[1] for one cycle 6 edges later, btn_long[1]=0 that cycle, and no btn_pulse.
REQ-032 SHALL check: all three raw bits rise on the same edge -> btn_pulse=3'b111 in one cycle.
REQ-033 SHALL check: reset pulsed while btn_raw[1] is held in REPEAT -> outputs 0 at once, no release; 6 edges after reset falls, one btn_pulse[1].
